decoder_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder. Successor to the combinational 3-to-8 decoder.
- Adds a valid/ready input handshake, an output enable, and three operating modes: level, timed pulse and walking scan.
- Drives select/strobe lines, e.g. bank selects or LED/debug scan chains, from a single clock domain.

---
 rtl/decoder_seq_if.sv | 21 ++
 rtl/decoder_seq.sv | 128 ++++++++++++
 tb/tb_decoder_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_seq_if.sv
// decoder_seq_if: request/response bundle for the sequenced one-hot decoder.
// master = code source (drives mode/en/in_valid/in), slave = decoder_seq.
interface decoder_seq_if #(
   parameter int IN_W = 3
);
   localparam int OUT_W = 2**IN_W;

   logic [1:0]       mode;
   logic             en;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in;
   logic [OUT_W-1:0] out;
   logic             out_valid;
   logic             busy;

   modport master (output mode, en, in_valid, in,
                   input  in_ready, out, out_valid, busy);
   modport slave  (input  mode, en, in_valid, in,
                   output in_ready, out, out_valid, busy);
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N one-hot decoder with valid/ready intake,
// output enable and LEVEL / PULSE / SCAN modes.
// Optional: define DECODER_SEQ_ACTIVE_LOW_EN for one-cold (inverted) out.
module decoder_seq #(
   parameter int IN_W      = 3,
   parameter int PULSE_LEN = 4
) (
   input logic        clk,
   input logic        rst_n,
   decoder_seq_if.slave bus
);
   localparam int OUT_W = 2**IN_W;

   typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

   state_t           state, state_nx;
   logic [IN_W-1:0]  code, code_nx;   // stored code (HOLD/PULSE) or scan index
   logic [7:0]       cnt, cnt_nx;     // pulse cycles remaining after this one
   logic [OUT_W-1:0] out_r, out_nx;
   logic             out_valid_r;
   logic             resume;          // previous cycle had en low: restore, do not advance
   logic             mismatch;
   logic             ready;
   logic             accept;

   function automatic logic [OUT_W-1:0] dec(input logic [IN_W-1:0] c);
      logic [OUT_W-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   // Intake: a mode that no longer matches the active state blocks accepts
   always_comb begin
      mismatch = 1'b0;
      case (state)
         HOLD:    mismatch = (bus.mode != 2'b00);
         PULSE:   mismatch = (bus.mode != 2'b01);
         SCAN:    mismatch = (bus.mode != 2'b10);
         default: mismatch = 1'b0;
      endcase
      ready  = bus.en && (bus.mode != 2'b11) && !mismatch &&
               ((bus.mode != 2'b01) || (state == IDLE));
      accept = bus.in_valid && ready;
   end

   // Next-state / next-output decode; out defaults to zero every cycle
   always_comb begin
      state_nx = state;
      code_nx  = code;
      cnt_nx   = cnt;
      out_nx   = '0;
      if (!bus.en) begin
         // frozen: state, code and counter hold, out blanks
      end else if (bus.mode == 2'b11 || mismatch) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (bus.mode)
            2'b00: begin
               if (accept) begin
                  state_nx = HOLD;
                  code_nx  = bus.in;
                  out_nx   = dec(bus.in);
               end else if (state == HOLD) begin
                  out_nx = dec(code);
               end
            end
            2'b01: begin
               if (accept) begin
                  state_nx = PULSE;
                  code_nx  = bus.in;
                  cnt_nx   = 8'(PULSE_LEN - 1);
                  out_nx   = dec(bus.in);
               end else if (state == PULSE) begin
                  if (resume) begin
                     out_nx = dec(code);
                  end else if (cnt == 8'd0) begin
                     state_nx = IDLE;
                  end else begin
                     cnt_nx = cnt - 8'd1;
                     out_nx = dec(code);
                  end
               end
            end
            default: begin
               if (accept) begin
                  state_nx = SCAN;
                  code_nx  = bus.in;
                  out_nx   = dec(bus.in);
               end else if (state == SCAN) begin
                  // index width is exactly log2(OUT_W), so +1 wraps naturally
                  code_nx = resume ? code : code + 1'b1;
                  out_nx  = dec(code_nx);
               end
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         code        <= '0;
         cnt         <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         resume      <= 1'b0;
      end else begin
         state       <= state_nx;
         code        <= code_nx;
         cnt         <= cnt_nx;
         out_r       <= out_nx;
         out_valid_r <= |out_nx;
         resume      <= !bus.en;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = (state == PULSE) || (state == SCAN);
`ifdef DECODER_SEQ_ACTIVE_LOW_EN
   assign bus.out = ~out_r;
`else
   assign bus.out = out_r;
`endif
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed test-plan sequences plus randomized traffic,
// all checked every cycle against a behavioural model of the decoder.
module tb_decoder_seq;
   localparam int IN_W  = 3;
   localparam int OUT_W = 8;
   localparam int PLEN  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decoder_seq_if #(.IN_W(IN_W)) bus ();
   decoder_seq #(.IN_W(IN_W), .PULSE_LEN(PLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Map an active-high one-hot value to the pin polarity of this build
   function automatic logic [OUT_W-1:0] pol(input logic [OUT_W-1:0] v);
`ifdef DECODER_SEQ_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   // Model: what is being shown (bit index or -1), by which activity
   // kind (0 none, 1 level, 2 pulse, 3 scan) and how many shown cycles remain
   int m_kind = 0, m_val = 0, m_left = 0, m_out = -1;
   bit m_resume = 1'b0;

   function automatic bit exp_ready();
      if (!bus.en || bus.mode == 2'b11) return 1'b0;
      if (m_kind != 0 && int'(bus.mode) != m_kind - 1) return 1'b0;
      if (bus.mode == 2'b01 && m_kind != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [OUT_W-1:0] exp_out();
      logic [OUT_W-1:0] v;
      v = '0;
      if (m_out >= 0) v[m_out] = 1'b1;
      return pol(v);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_kind = 0; m_val = 0; m_left = 0; m_out = -1; m_resume = 1'b0;
      end else begin
         bit acc;
         acc = bus.in_valid && exp_ready();
         if (!bus.en) begin
            m_out = -1;
            m_resume = 1'b1;
         end else begin
            if (bus.mode == 2'b11 || (m_kind != 0 && int'(bus.mode) != m_kind - 1)) begin
               m_kind = 0; m_out = -1;
            end else begin
               case (bus.mode)
                  2'b00: begin
                     if (acc) begin m_kind = 1; m_val = int'(bus.in); end
                     m_out = (m_kind == 1) ? m_val : -1;
                  end
                  2'b01: begin
                     if (acc) begin
                        m_kind = 2; m_val = int'(bus.in); m_left = PLEN; m_out = m_val;
                     end else if (m_kind == 2) begin
                        if (!m_resume) m_left--;
                        if (m_left == 0) begin m_kind = 0; m_out = -1; end
                        else m_out = m_val;
                     end else m_out = -1;
                  end
                  default: begin
                     if (acc) begin m_kind = 3; m_val = int'(bus.in); end
                     else if (m_kind == 3 && !m_resume) m_val = (m_val + 1) % OUT_W;
                     m_out = (m_kind == 3) ? m_val : -1;
                  end
               endcase
            end
            m_resume = 1'b0;
         end
      end
   end

   // Compare DUT against the model on every falling edge out of reset
   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("out", bus.out, exp_out());
         check("out_valid", bus.out_valid, m_out >= 0);
         check("busy", bus.busy, m_kind == 2 || m_kind == 3);
         check("in_ready", bus.in_ready, exp_ready());
         check("onehot0", $onehot0(pol(bus.out)), 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] md, input logic e, input logic v, input int c);
      bus.mode = md; bus.en = e; bus.in_valid = v; bus.in = IN_W'(c);
   endtask

   logic [OUT_W-1:0] lv [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      drive(2'b00, 1'b1, 1'b0, 0);
      repeat (2) tick();
      check("rst_out", bus.out, pol(8'h00));
      rst_n = 1'b1;
      chk_on = 1'b1;

      // async reset while showing 8'h10
      drive(2'b00, 1'b1, 1'b1, 4);
      tick();
      check("pre_rst_out", bus.out, pol(8'h10));
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_out", bus.out, pol(8'h00));
      check("rst_async_vld", bus.out_valid, 0);
      check("rst_async_busy", bus.busy, 0);
      tick();
      rst_n = 1'b1;
      #1;
      check("rel_ready", bus.in_ready, 1);
      check("rel_busy", bus.busy, 0);

      // LEVEL sweep
      for (int i = 0; i < 8; i++) begin
         drive(2'b00, 1'b1, 1'b1, i);
         tick();
         check("level_out", bus.out, pol(lv[i]));
         check("level_vld", bus.out_valid, 1);
      end

      // PULSE: mode change out of HOLD first, then accept 5
      drive(2'b01, 1'b1, 1'b0, 0);
      tick();
      check("pulse_pre", bus.out, pol(8'h00));
      drive(2'b01, 1'b1, 1'b1, 5);
      tick();
      for (int k = 0; k < PLEN; k++) begin
         check("pulse_on", bus.out, pol(8'h20));
         drive(2'b01, 1'b1, 1'b1, 2);
         if (k < PLEN - 1) tick();
      end
      bus.in_valid = 1'b0;
      tick();
      check("pulse_off", bus.out, pol(8'h00));
      check("pulse_ready", bus.in_ready, 1);

      // SCAN with wrap, then mid-scan accept
      drive(2'b10, 1'b1, 1'b1, 6);
      tick();
      check("scan0", bus.out, pol(8'h40));
      bus.in_valid = 1'b0;
      tick(); check("scan1", bus.out, pol(8'h80));
      tick(); check("scan2", bus.out, pol(8'h01));
      tick(); check("scan3", bus.out, pol(8'h02));
      tick(); check("scan4", bus.out, pol(8'h04));
      drive(2'b10, 1'b1, 1'b1, 3);
      tick(); check("scan_acc", bus.out, pol(8'h08));

      // en gating at index 2
      drive(2'b10, 1'b1, 1'b1, 2);
      tick(); check("gate_at2", bus.out, pol(8'h04));
      drive(2'b10, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         tick(); check("gate_off", bus.out, pol(8'h00));
      end
      bus.en = 1'b1;
      tick(); check("gate_restore", bus.out, pol(8'h04));
      tick(); check("gate_adv", bus.out, pol(8'h08));

      // mode switch mid-pulse
      drive(2'b01, 1'b1, 1'b0, 0);
      tick();
      drive(2'b01, 1'b1, 1'b1, 1);
      tick(); check("ms_p1", bus.out, pol(8'h02));
      bus.in_valid = 1'b0;
      tick(); check("ms_p2", bus.out, pol(8'h02));
      tick(); check("ms_p3", bus.out, pol(8'h02));
      drive(2'b00, 1'b1, 1'b1, 7);
      #1 check("ms_ready", bus.in_ready, 0);
      tick();
      check("ms_out", bus.out, pol(8'h00));
      check("ms_busy", bus.busy, 0);
      tick();
      check("ms_after", bus.out, pol(8'h80));

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0)
            bus.mode = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         bus.en       = ($urandom_range(0, 9) != 0);
         bus.in_valid = ($urandom_range(0, 2) != 0);
         bus.in       = IN_W'($urandom_range(0, OUT_W - 1));
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            #1 check("rnd_rst_out", bus.out, pol(8'h00));
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
